// File: rtl/log_lanes_mover_if.sv
// Frame-controller <-> log lane mover bundle: frame strobes and speed level in, log layout and per-lane deltas out.
interface log_lanes_mover_if #(
   parameter int NUM_LANES     = 5,
   parameter int LOGS_PER_LANE = 3
);
   localparam int NUM_OF_LOGS = NUM_LANES * LOGS_PER_LANE;

   logic                         startOfFrame;
   logic                         enable;
   logic                         restart;
   logic [1:0]                   level;
   logic [NUM_OF_LOGS-1:0][10:0] ObjectStartX;
   logic [NUM_OF_LOGS-1:0][10:0] ObjectStartY;
   logic [NUM_LANES-1:0][7:0]    lane_dx;       // two's complement pixels per lane
   logic                         update_done;
   logic                         overrun;

   modport master (
      output startOfFrame, enable, restart, level,
      input  ObjectStartX, ObjectStartY, lane_dx, update_done, overrun
   );
   modport slave (
      input  startOfFrame, enable, restart, level,
      output ObjectStartX, ObjectStartY, lane_dx, update_done, overrun
   );
endinterface

// File: rtl/log_lanes_mover.sv
// River log position generator: one lane per cycle after each frame strobe, Q11.4 positions with X wrap.
// Optional macro LOG_SPEEDUP_EN: speed multiplier = level + 1, latched when each update sequence starts.
module log_lanes_mover #(
   parameter int NUM_LANES     = 5,
   parameter int LOGS_PER_LANE = 3,
   parameter int SCREEN_W      = 640,
   parameter int LANE0_Y       = 80,
   parameter int LANE_PITCH    = 32,
   parameter int LANE_STAGGER  = 40,
   parameter int BASE_SPEED_Q4 = 16,
   parameter int SPEED_STEP_Q4 = 8
) (
   input logic              CLK,
   input logic              RESETn,
   log_lanes_mover_if.slave bus
);
   localparam int                NUM_OF_LOGS = NUM_LANES * LOGS_PER_LANE;
   localparam int                LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);
   localparam logic [15:0]       WRAP_Q4     = 16'(SCREEN_W * 16);

   typedef enum logic [0:0] {IDLE = 1'b0, UPDATE = 1'b1} state_t;

   state_t             state_r, state_nxt_s;
   logic [LANE_W-1:0]  lane_r, lane_nxt_s;
   logic               start_s, write_s, done_nxt_s, ovr_set_s;
   logic               done_r, ovr_r;
   logic [2:0]         mult_s;
   logic [7:0]         step_s;
   logic [15:0]        step_ext_s;
   logic signed [16:0] step_sgn_s;
   logic [NUM_LANES-1:0][14:0] head_pos_s;

   function automatic logic [7:0] lane_step(input logic [LANE_W-1:0] lane, input logic [2:0] mult);
      return 8'((BASE_SPEED_Q4 + int'(lane) * SPEED_STEP_Q4) * int'(mult));
   endfunction

`ifdef LOG_SPEEDUP_EN
   logic [2:0] mult_r;

   // frame multiplier, captured as the update sequence starts and held for that frame
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         mult_r <= 3'd1;
      end else if (bus.restart) begin
         mult_r <= 3'd1;
      end else if (start_s) begin
         mult_r <= {1'b0, bus.level} + 3'd1;
      end else begin
         mult_r <= mult_r;
      end
   end
   assign mult_s = mult_r;
`else
   logic [1:0] unused_level;
   assign unused_level = bus.level;
   assign mult_s       = 3'd1;
`endif

   assign step_s     = lane_step(lane_r, mult_s);
   assign step_ext_s = {8'd0, step_s};
   assign step_sgn_s = $signed({9'd0, step_s});

   // sequencer state register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_r <= IDLE;
         lane_r  <= '0;
      end else begin
         state_r <= state_nxt_s;
         lane_r  <= lane_nxt_s;
      end
   end

   // next state and per-cycle strobes; restart aborts any sequence in flight
   always_comb begin
      state_nxt_s = state_r;
      lane_nxt_s  = lane_r;
      start_s     = 1'b0;
      write_s     = 1'b0;
      done_nxt_s  = 1'b0;
      ovr_set_s   = 1'b0;
      if (bus.restart) begin
         state_nxt_s = IDLE;
         lane_nxt_s  = '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.startOfFrame) begin
                  state_nxt_s = UPDATE;
                  lane_nxt_s  = '0;
                  start_s     = 1'b1;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            UPDATE: begin
               write_s   = 1'b1;
               ovr_set_s = bus.startOfFrame;
               if (lane_r == LANE_LAST) begin
                  state_nxt_s = IDLE;
                  lane_nxt_s  = '0;
                  done_nxt_s  = 1'b1;
               end else begin
                  lane_nxt_s = lane_r + LANE_W'(1);
               end
            end
            default: begin
               state_nxt_s = IDLE;
               lane_nxt_s  = '0;
            end
         endcase
      end
   end

   // completion pulse and sticky overrun flag
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         done_r <= 1'b0;
         ovr_r  <= 1'b0;
      end else if (bus.restart) begin
         done_r <= 1'b0;
         ovr_r  <= 1'b0;
      end else begin
         done_r <= done_nxt_s;
         ovr_r  <= ovr_r | ovr_set_s;
      end
   end

   assign bus.update_done = done_r;
   assign bus.overrun     = ovr_r;

   for (genvar g = 0; g < NUM_OF_LOGS; g++) begin : g_log
      localparam int                LANE     = g / LOGS_PER_LANE;
      localparam logic [LANE_W-1:0] LANE_IDX = LANE_W'(LANE);
      localparam logic [14:0]       INIT_POS = 15'(((((g % LOGS_PER_LANE) * (SCREEN_W / LOGS_PER_LANE))
                                                    + LANE * LANE_STAGGER) % SCREEN_W) * 16);
      localparam logic [10:0]       INIT_Y   = 11'(LANE0_Y + LANE * LANE_PITCH);

      logic [14:0] pos_r;
      logic [10:0] y_r;
      logic [15:0] cur_s;
      logic [14:0] nxt_s;

      assign cur_s = {1'b0, pos_r};

      // one frame step with wrap: even lanes move right, odd lanes move left
      always_comb begin
         nxt_s = pos_r;
         if (LANE % 2 == 0) begin
            if ((cur_s + step_ext_s) >= WRAP_Q4) begin
               nxt_s = 15'(cur_s + step_ext_s - WRAP_Q4);
            end else begin
               nxt_s = 15'(cur_s + step_ext_s);
            end
         end else if (cur_s < step_ext_s) begin
            nxt_s = 15'(cur_s + WRAP_Q4 - step_ext_s);
         end else begin
            nxt_s = 15'(cur_s - step_ext_s);
         end
      end

      // position reloads on reset/restart and advances in its lane's slot when enabled
      always_ff @(posedge CLK or negedge RESETn) begin
         if (!RESETn) begin
            pos_r <= INIT_POS;
            y_r   <= INIT_Y;
         end else if (bus.restart) begin
            pos_r <= INIT_POS;
            y_r   <= INIT_Y;
         end else begin
            y_r <= y_r;
            if (write_s && bus.enable && (lane_r == LANE_IDX)) begin
               pos_r <= nxt_s;
            end else begin
               pos_r <= pos_r;
            end
         end
      end

      assign bus.ObjectStartX[g] = pos_r[14:4];
      assign bus.ObjectStartY[g] = y_r;

      if (g % LOGS_PER_LANE == 0) begin : g_head
         assign head_pos_s[LANE] = pos_r;
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      localparam logic [LANE_W-1:0] LANE_IDX = LANE_W'(l);

      logic signed [16:0] old_s, unw_s;
      logic [7:0]         dx_s, dx_r;

      // delta of the lead log measured before wrap, so wrap frames still report the true step
      assign old_s = $signed({2'b00, head_pos_s[l]});
      assign unw_s = (l % 2 == 0) ? (old_s + step_sgn_s) : (old_s - step_sgn_s);
      assign dx_s  = 8'((unw_s >>> 3'd4) - (old_s >>> 3'd4));

      // lane delta register: written in this lane's slot, zero while frozen
      always_ff @(posedge CLK or negedge RESETn) begin
         if (!RESETn) begin
            dx_r <= 8'd0;
         end else if (bus.restart) begin
            dx_r <= 8'd0;
         end else if (write_s && (lane_r == LANE_IDX)) begin
            dx_r <= bus.enable ? dx_s : 8'd0;
         end else begin
            dx_r <= dx_r;
         end
      end

      assign bus.lane_dx[l] = dx_r;
   end
endmodule

// File: tb/tb_log_lanes_mover.sv
// Scoreboard bench for log_lanes_mover: stimulus queues expectations, a negedge monitor compares them.
module tb_log_lanes_mover;
   typedef struct {
      int    stamp;
      string name;
      int    sel;
      int    idx;
      int    val;
   } exp_t;

   localparam int SEL_X = 0, SEL_Y = 1, SEL_DX = 2, SEL_DONE = 3, SEL_OVR = 4, SEL_CNT = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   log_lanes_mover_if #(.NUM_LANES(5), .LOGS_PER_LANE(3)) bus ();
   log_lanes_mover dut (.CLK(clk), .RESETn(rst_n), .bus(bus));

   exp_t timed_q[$];
   exp_t done_q[$];
   int   cyc      = 0;
   int   done_cnt = 0;
   int   n_vec    = 0;
   int   n_bad    = 0;

   initial forever #5 clk = ~clk;

   function automatic int sample(input int sel, input int idx);
      logic [3:0] i4;
      logic [2:0] i3;
      i4 = idx[3:0];
      i3 = idx[2:0];
      case (sel)
         SEL_X:    return int'(bus.ObjectStartX[i4]);
         SEL_Y:    return int'(bus.ObjectStartY[i4]);
         SEL_DX:   return int'($signed(bus.lane_dx[i3]));
         SEL_DONE: return int'(bus.update_done);
         SEL_OVR:  return int'(bus.overrun);
         SEL_CNT:  return done_cnt;
         default:  return -9999;
      endcase
   endfunction

   task automatic check(input exp_t e, input bit late);
      int act;
      act   = sample(e.sel, e.idx);
      n_vec = n_vec + 1;
      if (late || (act != e.val)) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d, expected %0d%s", e.name, act, e.val, late ? " (slot missed)" : "");
      end
   endtask

   task automatic at(input int stamp, input string name, input int sel, input int idx, input int val);
      exp_t e;
      e.stamp = stamp; e.name = name; e.sel = sel; e.idx = idx; e.val = val;
      timed_q.push_back(e);
   endtask

   task automatic on_done(input string name, input int sel, input int idx, input int val);
      exp_t e;
      e.stamp = 0; e.name = name; e.sel = sel; e.idx = idx; e.val = val;
      done_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame();
      bus.startOfFrame = 1'b1;
      tick(1);
      bus.startOfFrame = 1'b0;
      tick(6);
   endtask

   // monitor: timed checks by negedge count, frame checks on each update_done pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (bus.update_done) done_cnt = done_cnt + 1;
         for (int k = timed_q.size() - 1; k >= 0; k--) begin
            if (timed_q[k].stamp <= cyc) begin
               e = timed_q[k];
               timed_q.delete(k);
               check(e, e.stamp != cyc);
            end
         end
         if (bus.update_done) begin
            while (done_q.size() > 0) begin
               e = done_q.pop_front();
               check(e, 1'b0);
            end
         end
      end
   end

   initial begin
      int c;
      exp_t e;
      bus.startOfFrame = 1'b0;
      bus.enable       = 1'b1;
      bus.restart      = 1'b0;
      bus.level        = 2'd0;
      tick(3);
      rst_n = 1'b1;

      c = cyc;
      at(c+1, "rst_x0", SEL_X, 0, 0);     at(c+1, "rst_x1", SEL_X, 1, 213);
      at(c+1, "rst_x3", SEL_X, 3, 40);    at(c+1, "rst_x14", SEL_X, 14, 586);
      at(c+1, "rst_y0", SEL_Y, 0, 80);    at(c+1, "rst_y5", SEL_Y, 5, 112);
      at(c+1, "rst_y14", SEL_Y, 14, 208);
      for (int i = 0; i < 5; i++) at(c+1, $sformatf("rst_dx%0d", i), SEL_DX, i, 0);
      at(c+2, "rst_done", SEL_DONE, 0, 0); at(c+2, "rst_ovr", SEL_OVR, 0, 0);
      tick(2);

      c = cyc;
      at(c+2, "f1_x0_before", SEL_X, 0, 0);
      at(c+3, "f1_x0", SEL_X, 0, 1);      at(c+3, "f1_dx0", SEL_DX, 0, 1);
      at(c+3, "f1_x3_hold", SEL_X, 3, 40);
      at(c+4, "f1_x3", SEL_X, 3, 38);     at(c+4, "f1_dx1", SEL_DX, 1, -2);
      at(c+6, "f1_done_early", SEL_DONE, 0, 0);
      at(c+7, "f1_done", SEL_DONE, 0, 1);
      at(c+8, "f1_done_after", SEL_DONE, 0, 0);
      on_done("f1_x2", SEL_X, 2, 427);   on_done("f1_x4", SEL_X, 4, 251);
      on_done("f1_x5", SEL_X, 5, 464);   on_done("f1_x6", SEL_X, 6, 82);
      on_done("f1_dx2", SEL_DX, 2, 2);   on_done("f1_x9", SEL_X, 9, 117);
      on_done("f1_dx3", SEL_DX, 3, -3);  on_done("f1_x12", SEL_X, 12, 163);
      on_done("f1_x14", SEL_X, 14, 589); on_done("f1_dx4", SEL_DX, 4, 3);
      frame();

      on_done("f2_x3", SEL_X, 3, 37);    on_done("f2_dx1", SEL_DX, 1, -1);
      on_done("f2_x0", SEL_X, 0, 2);     on_done("f2_dx0", SEL_DX, 0, 1);
      on_done("f2_x9", SEL_X, 9, 115);   on_done("f2_dx3", SEL_DX, 3, -2);
      frame();

      for (int f = 3; f <= 27; f++) begin
         if (f == 17) begin
            on_done("f17_x14", SEL_X, 14, 637);
         end else if (f == 18) begin
            on_done("f18_x14_wrap", SEL_X, 14, 0);
            on_done("f18_dx4", SEL_DX, 4, 3);
         end else if (f == 26) begin
            on_done("f26_x3", SEL_X, 3, 1);
            on_done("f26_dx1", SEL_DX, 1, -1);
         end else if (f == 27) begin
            on_done("f27_x3_wrap", SEL_X, 3, 639);
            on_done("f27_dx1", SEL_DX, 1, -2);
            on_done("f27_x0", SEL_X, 0, 27);
            on_done("f27_x12", SEL_X, 12, 241);
            on_done("f27_x14", SEL_X, 14, 27);
         end else begin
            c = cyc;
         end
         frame();
      end
      at(cyc+1, "cnt27", SEL_CNT, 0, 27);
      tick(2);

      c = cyc;
      at(c+3, "ovr_before", SEL_OVR, 0, 0);
      at(c+4, "ovr_set", SEL_OVR, 0, 1);
      at(c+7, "ovr_done", SEL_DONE, 0, 1);
      at(c+9, "ovr_no_second", SEL_DONE, 0, 0);
      at(c+12, "ovr_cnt", SEL_CNT, 0, 28);
      at(c+12, "ovr_sticky", SEL_OVR, 0, 1);
      on_done("ovr_x0", SEL_X, 0, 28);
      bus.startOfFrame = 1'b1; tick(1);
      bus.startOfFrame = 1'b0; tick(1);
      bus.startOfFrame = 1'b1; tick(1);
      bus.startOfFrame = 1'b0; tick(10);

      c = cyc;
      at(c+2, "rs_ovr", SEL_OVR, 0, 0);   at(c+2, "rs_x0", SEL_X, 0, 0);
      at(c+2, "rs_x3", SEL_X, 3, 40);     at(c+2, "rs_x14", SEL_X, 14, 586);
      at(c+2, "rs_dx0", SEL_DX, 0, 0);    at(c+2, "rs_dx1", SEL_DX, 1, 0);
      at(c+2, "rs_dx4", SEL_DX, 4, 0);
      bus.restart = 1'b1; tick(1);
      bus.restart = 1'b0; tick(2);

      on_done("r1_x0", SEL_X, 0, 1);     on_done("r1_x3", SEL_X, 3, 38);
      on_done("r1_dx1", SEL_DX, 1, -2);
      frame();

      bus.enable = 1'b0;
      for (int f = 0; f < 3; f++) begin
         on_done($sformatf("en0_x0_%0d", f), SEL_X, 0, 1);
         on_done($sformatf("en0_x3_%0d", f), SEL_X, 3, 38);
         on_done($sformatf("en0_x9_%0d", f), SEL_X, 9, 117);
         on_done($sformatf("en0_x12_%0d", f), SEL_X, 12, 163);
         on_done($sformatf("en0_dx0_%0d", f), SEL_DX, 0, 0);
         on_done($sformatf("en0_dx1_%0d", f), SEL_DX, 1, 0);
         on_done($sformatf("en0_dx4_%0d", f), SEL_DX, 4, 0);
         frame();
      end
      at(cyc+1, "en0_cnt", SEL_CNT, 0, 32);
      tick(2);

      bus.enable = 1'b1;
      c = cyc;
      at(c+3, "ab_x0_step", SEL_X, 0, 2);
      at(c+4, "ab_x0", SEL_X, 0, 0);      at(c+4, "ab_dx0", SEL_DX, 0, 0);
      at(c+5, "ab_x3", SEL_X, 3, 40);     at(c+5, "ab_dx1", SEL_DX, 1, 0);
      at(c+7, "ab_no_done", SEL_DONE, 0, 0);
      at(c+12, "ab_cnt", SEL_CNT, 0, 32);
      bus.startOfFrame = 1'b1; tick(1);
      bus.startOfFrame = 1'b0; tick(1);
      bus.restart      = 1'b1; tick(1);
      bus.restart      = 1'b0; tick(10);

      bus.level = 2'd3;
`ifdef LOG_SPEEDUP_EN
      on_done("lv_x0", SEL_X, 0, 4);     on_done("lv_dx0", SEL_DX, 0, 4);
      on_done("lv_x3", SEL_X, 3, 34);    on_done("lv_dx1", SEL_DX, 1, -6);
`else
      on_done("lv_x0", SEL_X, 0, 1);     on_done("lv_dx0", SEL_DX, 0, 1);
      on_done("lv_x3", SEL_X, 3, 38);    on_done("lv_dx1", SEL_DX, 1, -2);
`endif
      frame();
      tick(3);

      while (done_q.size() > 0) begin
         e = done_q.pop_front();
         n_vec = n_vec + 1;
         n_bad = n_bad + 1;
         $display("FAIL %s: got no update_done, expected %0d", e.name, e.val);
      end
      while (timed_q.size() > 0) begin
         e = timed_q.pop_front();
         n_vec = n_vec + 1;
         n_bad = n_bad + 1;
         $display("FAIL %s: got unchecked slot %0d, expected %0d", e.name, e.stamp, e.val);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
